// File: rtl/lcd_arb_pkg.sv
// Shared types and width helpers for the LCD bus arbiter.
package lcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must reach the value v.
    function automatic int cnt_w(input int v);
        return (v <= 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Client request/grant handshake plus the shared LCD pin bus.
interface lcd_bus_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8
);
    import lcd_arb_pkg::*;

    localparam int OW = owner_w(NUM_CH);

    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        ch_rs;
    logic [NUM_CH-1:0]        ch_rw;
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        gnt;
    logic [OW-1:0]            owner;
    logic                     busy;
    logic                     timeout;
    logic                     LCD_RS;
    logic                     LCD_RW;
    logic                     LCD_EN;
    logic [DATA_W-1:0]        LCD_DATA;

    // Arbiter side.
    modport slave (
        input  req, ch_rs, ch_rw, ch_en, ch_data,
        output gnt, owner, busy, timeout, LCD_RS, LCD_RW, LCD_EN, LCD_DATA
    );

    // Client / pin side.
    modport master (
        output req, ch_rs, ch_rw, ch_en, ch_data,
        input  gnt, owner, busy, timeout, LCD_RS, LCD_RW, LCD_EN, LCD_DATA
    );

endinterface

// File: rtl/lcd_rr_picker.sv
// Combinational winner selection: first eligible channel at or after the
// start index, wrapping. Fixed-priority mode simply starts from channel 0.
module lcd_rr_picker #(
    parameter int NUM_CH = 3,
    parameter int OW     = 2
) (
    input  logic [NUM_CH-1:0] elig,
    input  logic [OW-1:0]     ptr,
    input  logic              rr_mode,
    output logic [NUM_CH-1:0] win_oh,
    output logic [OW-1:0]     win_idx,
    output logic              win_any
);

    logic [OW-1:0] start;
    logic [OW:0]   sum;
    logic [OW-1:0] idx;

    // Scan channels in rotated order and keep the first eligible one.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        sum     = '0;
        idx     = '0;
        start   = rr_mode ? ptr : '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, start} + (OW+1)'(i);
            if (sum >= (OW+1)'(NUM_CH)) begin
                sum = sum - (OW+1)'(NUM_CH);
            end
            idx = sum[OW-1:0];
            if (!win_any && elig[idx]) begin
                win_any      = 1'b1;
                win_oh[idx]  = 1'b1;
                win_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// N-channel owner arbiter for the character-LCD bus: request/grant handshake,
// idle gap between owners, optional hold limit with revoke, init lockout.
module lcd_bus_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 8,
    parameter int RR_MODE  = 1,
    parameter int GAP_CYC  = 50,
    parameter int MAX_HOLD = 0
) (
    input  logic             CLK_50M,
    input  logic             rst,
    input  logic             init_done,
    lcd_bus_arbiter_if.slave bus
);

    localparam int OW = owner_w(NUM_CH);
    localparam int HW = cnt_w(MAX_HOLD);
    localparam int GW = cnt_w(GAP_CYC);
    localparam logic [HW-1:0]     HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [GW-1:0]     GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [NUM_CH-1:0] CH0_MASK  = NUM_CH'(1);

    arb_state_e          state_q, state_d;
    logic [NUM_CH-1:0]   gnt_q, gnt_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;
    logic [OW-1:0]       ptr_q, ptr_d;
    logic [NUM_CH-1:0]   revoked_q, revoked_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                lcd_rs_q, lcd_rs_d;
    logic                lcd_rw_q, lcd_rw_d;
    logic                lcd_en_q, lcd_en_d;
    logic [DATA_W-1:0]   lcd_data_q, lcd_data_d;

    logic [NUM_CH-1:0]   elig;
    logic [NUM_CH-1:0]   win_oh;
    logic [OW-1:0]       win_idx;
    logic                win_any;
    logic                own_req;
    logic                hold_expired;

    assign elig         = bus.req & ~revoked_q & (init_done ? '1 : CH0_MASK);
    assign own_req      = bus.req[owner_q];
    assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    lcd_rr_picker #(
        .NUM_CH (NUM_CH),
        .OW     (OW)
    ) u_picker (
        .elig    (elig),
        .ptr     (ptr_q),
        .rr_mode (1'(RR_MODE != 0)),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    // Next-state, counters, revoke mask and LCD pass-through.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        timeout_d  = 1'b0;
        ptr_d      = ptr_q;
        revoked_d  = revoked_q & bus.req;
        hold_d     = hold_q;
        gap_d      = gap_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_rw_d   = lcd_rw_q;
        lcd_en_d   = lcd_en_q;
        lcd_data_d = lcd_data_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = GRANT;
                    gnt_d   = win_oh;
                    owner_d = win_idx;
                    hold_d  = '0;
                    if (RR_MODE != 0) begin
                        ptr_d = (win_idx == OW'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
                    end
                end
            end
            GRANT: begin
                lcd_rs_d   = bus.ch_rs[owner_q];
                lcd_rw_d   = bus.ch_rw[owner_q];
                lcd_en_d   = bus.ch_en[owner_q];
                lcd_data_d = bus.ch_data[owner_q*DATA_W +: DATA_W];
                hold_d     = hold_q + 1'b1;
                // Release takes precedence over expiry: a revoke only happens
                // when the owner is still requesting.
                if (!own_req || hold_expired) begin
                    gnt_d    = '0;
                    lcd_en_d = 1'b0;
                    lcd_rw_d = 1'b0;
                    gap_d    = '0;
                    state_d  = (GAP_CYC == 0) ? IDLE : GAP;
                    if (own_req) begin
                        timeout_d          = 1'b1;
                        revoked_d[owner_q] = 1'b1;
                    end
                end
            end
            GAP: begin
                lcd_en_d = 1'b0;
                lcd_rw_d = 1'b0;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM and output registers with synchronous reset.
    always_ff @(posedge CLK_50M) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ptr_q      <= '0;
            revoked_q  <= '0;
            hold_q     <= '0;
            gap_q      <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_rw_q   <= 1'b0;
            lcd_en_q   <= 1'b0;
            lcd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            ptr_q      <= ptr_d;
            revoked_q  <= revoked_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_rw_q   <= lcd_rw_d;
            lcd_en_q   <= lcd_en_d;
            lcd_data_q <= lcd_data_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;
    assign bus.LCD_RS   = lcd_rs_q;
    assign bus.LCD_RW   = lcd_rw_q;
    assign bus.LCD_EN   = lcd_en_q;
    assign bus.LCD_DATA = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: two instances (round-robin with gap and hold
// limit; fixed priority with no gap and short hold limit) share one stimulus
// and are compared every cycle against a behavioural model.
module tb_lcd_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic [2:0]  req;
    logic [2:0]  ch_rs, ch_rw, ch_en;
    logic [23:0] ch_data;
    logic        chk_on = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lcd_bus_arbiter_if #(.NUM_CH(3), .DATA_W(8)) bus_a ();
    lcd_bus_arbiter_if #(.NUM_CH(3), .DATA_W(8)) bus_b ();

    assign bus_a.req = req;  assign bus_a.ch_rs = ch_rs;  assign bus_a.ch_rw = ch_rw;
    assign bus_a.ch_en = ch_en;  assign bus_a.ch_data = ch_data;
    assign bus_b.req = req;  assign bus_b.ch_rs = ch_rs;  assign bus_b.ch_rw = ch_rw;
    assign bus_b.ch_en = ch_en;  assign bus_b.ch_data = ch_data;

    lcd_bus_arbiter #(.NUM_CH(3), .DATA_W(8), .RR_MODE(1), .GAP_CYC(50), .MAX_HOLD(20)) dut_a (
        .CLK_50M(clk), .rst(rst), .init_done(init_done), .bus(bus_a));
    lcd_bus_arbiter #(.NUM_CH(3), .DATA_W(8), .RR_MODE(0), .GAP_CYC(0), .MAX_HOLD(7)) dut_b (
        .CLK_50M(clk), .rst(rst), .init_done(init_done), .bus(bus_b));

    // Behavioural model: who owns the bus, how long they have held it, how
    // many idle cycles remain, and the pin values.
    typedef struct {
        bit       granted;
        int       owner;
        int       held;
        int       gap_left;
        int       ptr;
        bit [2:0] rev;
        bit       timeout;
        bit       rs, rw, en;
        bit [7:0] data;
    } mdl_t;

    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};

    function automatic mdl_t mdl_step(mdl_t m, int rr, int gap, int maxh);
        mdl_t nx;
        int o;
        int w;
        nx = m;
        if (rst) begin
            nx = '{default: 0};
            return nx;
        end
        nx.timeout = 0;
        for (int i = 0; i < 3; i++) begin
            if (((req >> i) & 3'd1) == 3'd0) nx.rev = nx.rev & ~3'(1 << i);
        end
        if (m.granted) begin
            o = m.owner;
            nx.rs   = ch_rs[o[1:0]];
            nx.rw   = ch_rw[o[1:0]];
            nx.en   = ch_en[o[1:0]];
            nx.data = 8'(ch_data >> (8 * o));
            if (!req[o[1:0]] || (maxh > 0 && m.held + 1 >= maxh)) begin
                nx.granted  = 0;
                nx.en       = 0;
                nx.rw       = 0;
                nx.gap_left = gap;
                if (req[o[1:0]]) begin
                    nx.timeout = 1;
                    nx.rev     = nx.rev | 3'(1 << o);
                end
            end else begin
                nx.held = m.held + 1;
            end
        end else if (m.gap_left > 0) begin
            nx.gap_left = m.gap_left - 1;
        end else begin
            w = -1;
            for (int k = 0; k < 3; k++) begin
                int c;
                c = (rr != 0) ? (m.ptr + k) % 3 : k;
                if (w < 0 && req[c[1:0]] && !m.rev[c[1:0]] && (init_done || c == 0)) w = c;
            end
            if (w >= 0) begin
                nx.granted = 1;
                nx.owner   = w;
                nx.held    = 0;
                if (rr != 0) nx.ptr = (w + 1) % 3;
            end
        end
        return nx;
    endfunction

    always @(posedge clk) begin
        ma <= mdl_step(ma, 1, 50, 20);
        mb <= mdl_step(mb, 0, 0, 7);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string nm, input logic [2:0] g, input logic [1:0] o,
                            input logic b, input logic t, input logic rs, input logic rw,
                            input logic en, input logic [7:0] d, input mdl_t m);
        chk({nm, ".gnt"},     32'(g),  m.granted ? (32'd1 << m.owner) : 32'd0);
        chk({nm, ".owner"},   32'(o),  32'(m.owner));
        chk({nm, ".busy"},    32'(b),  32'(m.granted || m.gap_left > 0));
        chk({nm, ".timeout"}, 32'(t),  32'(m.timeout));
        chk({nm, ".rs"},      32'(rs), 32'(m.rs));
        chk({nm, ".rw"},      32'(rw), 32'(m.rw));
        chk({nm, ".en"},      32'(en), 32'(m.en));
        chk({nm, ".data"},    32'(d),  32'(m.data));
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp_inst("A", bus_a.gnt, bus_a.owner, bus_a.busy, bus_a.timeout,
                     bus_a.LCD_RS, bus_a.LCD_RW, bus_a.LCD_EN, bus_a.LCD_DATA, ma);
            cmp_inst("B", bus_b.gnt, bus_b.owner, bus_b.busy, bus_b.timeout,
                     bus_b.LCD_RS, bus_b.LCD_RW, bus_b.LCD_EN, bus_b.LCD_DATA, mb);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int en_cnt, gap_cnt, en_in_gap, hold_cnt;
        bit found;

        rst = 1'b1; init_done = 1'b0; req = '0;
        ch_rs = '0; ch_rw = '0; ch_en = '0; ch_data = '0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_gnt",   32'(bus_a.gnt), 0);
        chk("rst_busy",  32'(bus_a.busy), 0);
        chk("rst_en",    32'(bus_a.LCD_EN), 0);
        rst = 1'b0;

        // Init lockout: only channel 0 may win while init_done is low.
        req = 3'b110;
        repeat (100) @(negedge clk);
        chk("lock_gnt_a", 32'(bus_a.gnt), 0);
        chk("lock_gnt_b", 32'(bus_b.gnt), 0);
        chk("lock_en_a",  32'(bus_a.LCD_EN), 0);
        req = 3'b111;
        @(negedge clk);
        chk("lock_ch0_a", 32'(bus_a.gnt), 32'b001);
        chk("lock_ch0_b", 32'(bus_b.gnt), 32'b001);

        // Pass-through: 12-cycle EN pulse with data 0x38 on channel 0.
        ch_data = {8'h55, 8'h66, 8'h38};
        ch_rs   = 3'b001;
        ch_en   = 3'b001;
        en_cnt  = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus_a.LCD_EN) en_cnt++;
            if (k == 11) ch_en = 3'b000;
        end
        chk("pass_en_len", 32'(en_cnt), 12);
        chk("pass_data",   32'(bus_a.LCD_DATA), 32'h38);
        chk("pass_rs",     32'(bus_a.LCD_RS), 1);

        // Gap: owner releases, channels 1 and 2 waiting.
        init_done = 1'b1;
        req = 3'b110;
        gap_cnt = 0; en_in_gap = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_a.gnt != 3'b000) break;
            gap_cnt++;
            if (bus_a.LCD_EN) en_in_gap++;
        end
        chk("gap_len",    32'(gap_cnt), 51);
        chk("gap_en",     32'(en_in_gap), 0);
        chk("rr_next",    32'(bus_a.gnt), 32'b010);
        chk("mdl_owner",  32'(ma.owner), 1);

        // Hold limit: channel 1 keeps requesting.
        hold_cnt = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_a.gnt != 3'b010) break;
            hold_cnt++;
        end
        chk("hold_len",   32'(hold_cnt), 20);
        chk("to_pulse",   32'(bus_a.timeout), 1);
        req = 3'b010;
        @(negedge clk);
        chk("to_one_cyc", 32'(bus_a.timeout), 0);
        repeat (80) @(negedge clk);
        chk("revoked",    32'(bus_a.gnt), 0);
        req = 3'b000;
        @(negedge clk);
        req = 3'b010;
        found = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus_a.gnt == 3'b010) begin found = 1; break; end
        end
        chk("regrant",    32'(found), 1);

        // Release in the same cycle as expiry: no timeout.
        repeat (19) @(negedge clk);
        chk("rel_exp_pre", 32'(bus_a.gnt), 32'b010);
        req = 3'b000;
        @(negedge clk);
        chk("rel_exp_gnt", 32'(bus_a.gnt), 0);
        chk("rel_exp_to",  32'(bus_a.timeout), 0);

        // Reset in the middle of an EN-high grant.
        req = 3'b100; ch_en = 3'b100; ch_rs = 3'b100;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_a.gnt == 3'b100) begin found = 1; break; end
        end
        chk("mid_grant",  32'(found), 1);
        @(negedge clk);
        chk("mid_en",     32'(bus_a.LCD_EN), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_gnt",   32'(bus_a.gnt), 0);
        chk("mrst_owner", 32'(bus_a.owner), 0);
        chk("mrst_busy",  32'(bus_a.busy), 0);
        chk("mrst_en",    32'(bus_a.LCD_EN), 0);
        chk("mrst_rs",    32'(bus_a.LCD_RS), 0);
        chk("mrst_data",  32'(bus_a.LCD_DATA), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_idle",  32'(bus_a.gnt), 32'b100);

        // Randomised traffic.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 24) == 0) req = req ^ 3'(1 << i);
            end
            ch_rs   = 3'($urandom);
            ch_rw   = 3'($urandom);
            ch_en   = 3'($urandom);
            ch_data = 24'($urandom);
            if ($urandom_range(0, 199) == 0) init_done = ~init_done;
            rst = ($urandom_range(0, 1499) == 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
